// File: rtl/demo_peck8_tx_if.sv
// Parallel-in handshake and serial-out strobe bundle of the demo_peck8_tx transmitter.
// The master side feeds words and observes the serial stream; the slave side is the transmitter.
interface demo_peck8_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sdata;
    logic             sen;
    logic             busy;
    logic             done;

    modport master (
        output din, din_valid,
        input  din_ready, sdata, sen, busy, done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, sdata, sen, busy, done
    );
endinterface

// File: rtl/demo_peck8_tx.sv
// Parallel-to-serial transmitter: one-entry input buffer, MSB-first bit stream with a
// one-cycle sen strobe per bit and an optional run of idle cycles after every bit.
module demo_peck8_tx #(
    parameter int WIDTH   = 8,
    parameter int BIT_GAP = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    demo_peck8_tx_if.slave bus
);
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH);
    localparam bit                HAS_GAP  = (BIT_GAP > 0);
    localparam logic [3:0]        GAP_LOAD = HAS_GAP ? 4'(BIT_GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] buf_q;
    logic [WIDTH-1:0] shreg;
    logic             buf_full;
    logic [CNT_W-1:0] bitcnt;
    logic [3:0]       gapcnt;
    logic             sdata_q;
    logic             sen_q;
    logic             busy_q;
    logic             done_q;

    logic accept;
    logic bit_end;
    logic do_xfer;
    logic do_bit;
    logic do_gap;
    logic do_idle;

    assign bus.din_ready = ~buf_full & rst_n;
    assign accept        = bus.din_valid & bus.din_ready;

    assign bus.sdata = sdata_q;
    assign bus.sen   = sen_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

    // bit_end marks the edge where the current bit (and its gap, if any) is finished
    always_comb begin
        state_nxt = state;
        bit_end   = 1'b0;
        do_xfer   = 1'b0;
        do_bit    = 1'b0;
        do_gap    = 1'b0;
        do_idle   = 1'b0;

        case (state)
            IDLE:    do_xfer = buf_full;
            SHIFT: begin
                if (HAS_GAP) do_gap  = 1'b1;
                else         bit_end = 1'b1;
            end
            GAP:     bit_end = (gapcnt == 4'd0);
            default: state_nxt = IDLE;
        endcase

        if (bit_end) begin
            if (bitcnt != LAST_BIT) do_bit  = 1'b1;
            else if (buf_full)      do_xfer = 1'b1;
            else                    do_idle = 1'b1;
        end

        if (do_xfer || do_bit) state_nxt = SHIFT;
        else if (do_gap)       state_nxt = GAP;
        else if (do_idle)      state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            buf_full <= 1'b0;
            bitcnt   <= '0;
            gapcnt   <= 4'd0;
            sdata_q  <= 1'b0;
            sen_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept)       buf_full <= 1'b1;
            else if (do_xfer) buf_full <= 1'b0;

            if (do_xfer) begin
                sdata_q <= buf_q[WIDTH-1];
                sen_q   <= 1'b1;
                bitcnt  <= CNT_W'(1);
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end else if (do_bit) begin
                sdata_q <= shreg[WIDTH-1];
                sen_q   <= 1'b1;
                bitcnt  <= bitcnt + CNT_W'(1);
                done_q  <= ((bitcnt + CNT_W'(1)) == LAST_BIT);
            end else if (do_gap) begin
                sen_q  <= 1'b0;
                done_q <= 1'b0;
                gapcnt <= GAP_LOAD;
            end else if (do_idle) begin
                sen_q  <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b0;
            end else if (state == GAP) begin
                gapcnt <= gapcnt - 4'd1;
            end
        end
    end

    // Word storage carries no reset; buf_full and the FSM decide whether it is meaningful.
    always_ff @(posedge clk) begin
        if (accept) buf_q <= bus.din;
        if (do_xfer)     shreg <= buf_q << 1;
        else if (do_bit) shreg <= shreg << 1;
    end
endmodule

// File: tb/tb_demo_peck8_tx.sv
// Directed bench for demo_peck8_tx: one instance without bit gaps, one with BIT_GAP=2,
// plus a small serial-in shift register standing in for the receiver.
module tb_demo_peck8_tx;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] rx;

    always #5 clk = ~clk;

    demo_peck8_tx_if #(.WIDTH(8)) b0 ();
    demo_peck8_tx_if #(.WIDTH(8)) b2 ();

    demo_peck8_tx #(.WIDTH(8), .BIT_GAP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    demo_peck8_tx #(.WIDTH(8), .BIT_GAP(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    always @(posedge clk) if (b0.sen) rx <= {rx[6:0], b0.sdata};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  w1;
        logic [15:0] s2;
        logic [23:0] s4;
        w1 = 8'hA5;
        s2 = 16'h3CF0;
        s4 = {8'hC3, 8'h21, 8'h29};

        rst_n = 1'b0;
        b0.din = '0; b0.din_valid = 1'b0;
        b2.din = '0; b2.din_valid = 1'b0;
        repeat (2) tick();
        check("rst_sen",   b0.sen, 0);
        check("rst_sdata", b0.sdata, 0);
        check("rst_busy",  b0.busy, 0);
        check("rst_done",  b0.done, 0);
        check("rst_rdy",   b0.din_ready, 0);
        check("rst_sen2",  b2.sen, 0);
        rst_n = 1'b1;
        #1;
        check("rdy_after_rst", b0.din_ready, 1);
        tick();

        // Single byte 0xA5
        b0.din = 8'hA5; b0.din_valid = 1'b1;
        tick();
        b0.din_valid = 1'b0;
        check("t1_rdy_c0", b0.din_ready, 0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            check($sformatf("t1_sen_c%0d", c),  b0.sen, (c <= 8));
            if (c <= 8) check($sformatf("t1_sdata_c%0d", c), b0.sdata, w1[8-c]);
            check($sformatf("t1_done_c%0d", c), b0.done, (c == 8));
            check($sformatf("t1_busy_c%0d", c), b0.busy, (c <= 8));
            check($sformatf("t1_rdy_c%0d", c),  b0.din_ready, 1);
        end

        // Back-to-back 0x3C then 0xF0
        b0.din = 8'h3C; b0.din_valid = 1'b1;
        tick();
        b0.din_valid = 1'b0;
        check("t2_rdy_c0", b0.din_ready, 0);
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c == 2) b0.din_valid = 1'b0;
            check($sformatf("t2_sen_c%0d", c), b0.sen, (c <= 16));
            if (c <= 16) check($sformatf("t2_sdata_c%0d", c), b0.sdata, s2[16-c]);
            check($sformatf("t2_done_c%0d", c), b0.done, (c == 8 || c == 16));
            check($sformatf("t2_busy_c%0d", c), b0.busy, (c <= 16));
            check($sformatf("t2_rdy_c%0d", c),  b0.din_ready, !(c >= 2 && c <= 8));
            if (c == 1) begin
                b0.din = 8'hF0; b0.din_valid = 1'b1;
            end
        end

        // BIT_GAP=2, 0x81
        b2.din = 8'h81; b2.din_valid = 1'b1;
        tick();
        b2.din_valid = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            tick();
            check($sformatf("t3_sen_c%0d", c), b2.sen, (c <= 22 && (c - 1) % 3 == 0));
            if (c <= 22 && (c - 1) % 3 == 0)
                check($sformatf("t3_sdata_c%0d", c), b2.sdata, (c == 1 || c == 22));
            check($sformatf("t3_done_c%0d", c), b2.done, (c == 22));
            check($sformatf("t3_busy_c%0d", c), b2.busy, (c <= 24));
        end

        // Backpressure: valid held, din changing every cycle
        b0.din = 8'hC3; b0.din_valid = 1'b1;
        tick();
        b0.din = 8'h20;
        for (int c = 1; c <= 26; c++) begin
            tick();
            check($sformatf("t4_sen_c%0d", c), b0.sen, (c <= 24));
            if (c <= 24) check($sformatf("t4_sdata_c%0d", c), b0.sdata, s4[24-c]);
            check($sformatf("t4_rdy_c%0d", c), b0.din_ready,
                  !((c >= 2 && c <= 8) || (c >= 10 && c <= 16)));
            if (c <= 9) b0.din = 8'(32 + c);
            else        b0.din_valid = 1'b0;
        end

        // Reset mid-word with a second word buffered
        b0.din = 8'hFF; b0.din_valid = 1'b1;
        tick();
        b0.din_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 2) b0.din_valid = 1'b0;
            check($sformatf("t5_sen_c%0d", c),   b0.sen, 1);
            check($sformatf("t5_sdata_c%0d", c), b0.sdata, 1);
            if (c == 1) begin
                b0.din = 8'h77; b0.din_valid = 1'b1;
            end
        end
        check("t5_rdy_buffered", b0.din_ready, 0);
        rst_n = 1'b0;
        tick();
        check("t5_rst_sen",   b0.sen, 0);
        check("t5_rst_sdata", b0.sdata, 0);
        check("t5_rst_busy",  b0.busy, 0);
        check("t5_rst_done",  b0.done, 0);
        check("t5_rst_rdy",   b0.din_ready, 0);
        rst_n = 1'b1;
        #1;
        check("t5_rel_rdy", b0.din_ready, 1);
        for (int c = 5; c <= 16; c++) begin
            tick();
            check($sformatf("t5_sen_c%0d", c),  b0.sen, 0);
            check($sformatf("t5_busy_c%0d", c), b0.busy, 0);
            check($sformatf("t5_rdy_c%0d", c),  b0.din_ready, 1);
        end

        // Loopback into the receiver shift register
        b0.din = 8'h5A; b0.din_valid = 1'b1;
        tick();
        b0.din_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 8) check("t6_done_c8", b0.done, 1);
            if (c == 9) check("t6_rx", rx, 8'h5A);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/demo_peck8_tx.md
# demo_peck8_tx

Parallel-to-serial transmitter that drives the serial side of the 8-bit bit-stream link consumed by the team's serial-in shift-register receiver. It accepts bytes over a valid/ready handshake and holds them in a one-entry buffer. Each byte is shifted out MSB first, one bit per strobe. Each bit is placed on `sdata` with a one-cycle `sen` strobe, which the receiver uses as its shift enable. Because the bit order is MSB first, the receiver ends up with `d[7]` in its bit 7.

## Interface
- `WIDTH`, default 8: bits per word; legal range 2..32.
- `BIT_GAP`, default 0: number of idle cycles (`sen`=0) inserted after every bit, including the last; legal range 0..15.

- `clk`: input, 1 bit. Single clock; all logic changes on its rising edge.
- `rst_n`: input, 1 bit. Reset is synchronous and active-low.
- `din`: input, `WIDTH` bits. Parallel word to transmit.
- `din_valid`: input, 1 bit. `din` holds a word.
- `din_ready`: output, 1 bit. Buffer is empty. Equals `~buf_full & rst_n` (combinational).
- `sdata`: output, 1 bit. Serial data, registered.
- `sen`: output, 1 bit. Bit strobe, registered; high for exactly one cycle per bit.
- `busy`: output, 1 bit. A word is in flight (shifting or in a gap), registered.
- `done`: output, 1 bit. One-cycle pulse coincident with the `sen` of the last bit (bit 0).

## Operation
- Accept: on an edge where `din_valid & din_ready`, `din` is captured into the buffer and `buf_full` is set.
- States:
  - IDLE: buffer empty, or waiting for a word.
  - SHIFT: a bit edge.
  - GAP: `BIT_GAP` idle cycles after a bit.
- IDLE → SHIFT on the first edge where `buf_full`=1 (the "transfer edge"). On that edge:
  - `shreg <= buf << 1`;
  - `sdata <= buf[WIDTH-1]`, `sen <= 1`;
  - `bitcnt <= 1`, `buf_full <= 0`, `busy <= 1`.
- SHIFT, subsequent bit edges:
  - `sdata <= shreg[WIDTH-1]`, `shreg <= shreg << 1`, `bitcnt++`, `sen <= 1`.
  - `done <= 1` on the edge emitting bit 0 (`bitcnt` reaches `WIDTH`).
- Gap handling:
  - If `BIT_GAP` > 0, every bit edge is followed by `BIT_GAP` edges in GAP, each with `sen <= 0` and `gapcnt` counting down.
  - `sdata` holds its last value during GAP.
- End of word (after bit 0 and its gap):
  - If `buf_full`: that edge is a new transfer edge, so words go out back-to-back with no extra cycle.
  - Otherwise: go to IDLE with `busy <= 0`, `sen <= 0`, `done <= 0`; `sdata` holds.
- The buffer may be refilled while shifting. `din_ready` returns high on the cycle after the transfer edge.
- Simultaneous accept and transfer cannot occur, because accept requires an empty buffer and transfer requires a full one.
- `shreg` never rotates. Rotation is purely a receiver feature and is not generated here.

## Timing
- Reset values when `rst_n`=0 at an edge:
  - `sdata`=0, `sen`=0, `busy`=0, `done`=0;
  - `buf_full`=0, `bitcnt`=0, `gapcnt`=0, state IDLE.
  - `din_ready`=0 while `rst_n`=0.
- Reset mid-word: the word and any buffered word are discarded. No further `sen` appears until a new accept.
- Latency: accept at edge k gives the first `sen` (bit `WIDTH-1`) registered at edge k+1, provided the block is IDLE.
- Word period is `WIDTH*(1+BIT_GAP)` cycles. With `BIT_GAP`=0 and the buffer kept full, `sen` stays high continuously.
- `busy` rises at the transfer edge. It falls at the edge after the last bit's gap ends, and only if no transfer occurs on that edge.
- `done` and the bit-0 `sen` are high in the same cycle.

## Test plan
- Single byte: `BIT_GAP`=0; accept 0xA5 at edge 0.
  - `sen`=1 in cycles 1..8, `sdata`=1,0,1,0,0,1,0,1.
  - `done`=1 in cycle 8 only; `busy`=0 from cycle 9.
- Back-to-back: accept 0x3C, then 0xF0 while shifting.
  - 16 contiguous `sen` cycles, bits 00111100 11110000.
  - `done` in cycles 8 and 16; `din_ready` low from accept until the cycle after the second transfer.
- Gap: `BIT_GAP`=2; accept 0x81.
  - `sen` high at cycles 1,4,7,…,22, with `sdata`=1 on the first and last strobes and 0 on the rest.
  - `busy` falls at cycle 25.
- Backpressure: hold `din_valid`=1 with a changing `din` while the buffer is full.
  - Only values sampled while `din_ready`=1 are transmitted; no word is duplicated or lost.
- Reset mid-word: assert `rst_n`=0 for one edge after the 3rd bit of 0xFF, with a word buffered.
  - Next cycle: all outputs are 0 and `din_ready`=1; no further `sen` appears.
- Loopback: connect `sdata`/`sen` to the receiver's `datain`/`en` and send 0x5A.
  - The receiver's `dataout` equals 0x5A in the cycle after `done`.
